imm_instr_packer: RTL

- Inverse of the immediate extender: takes a 32-bit instruction template plus a signed immediate and an immSrc type code (00 I, 01 S, 10 B, 11 J) and scatters the immediate into the RV32I bit positions.
- Writes each packed word sequentially into instruction memory through a single write port.
- Used as the program loader that fills instruction memory before the single-cycle and multicycle cores run.

---
 rtl/imm_instr_packer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/imm_instr_packer.sv
// imm_instr_packer: scatters a signed immediate into an RV32I instruction
// template (I/S/B/J) and writes each packed word to instruction memory.
// Ports: clk, reset (async, active-high), start/base_addr open a session;
//   in_valid/in_ready/in_last + immSrc/imm/instr_tmpl form the input stream;
//   mem_we/mem_addr/mem_wdata drive the memory write port;
//   count = words written, done = session finished, err = sticky range error.
// Optional: define IMM_RANGE_CHECK_EN to reject out-of-range immediates
//   (no write, err set); otherwise err is tied to 0 and bits are truncated.
module imm_instr_packer #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [1:0]        immSrc,
   input  logic [31:0]       imm,
   input  logic [31:0]       instr_tmpl,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [CNT_W-1:0]  count,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_ENCODE,
      S_WRITE,
      S_DONE
   } state_t;

   state_t      state;
   state_t      state_nx;

   logic [31:0] tmpl_q;
   logic [31:0] imm_q;
   logic [1:0]  src_q;
   logic        last_q;
   logic        bad_q;
   logic        err_q;
   logic [31:0] packed_c;
   logic        bad_c;

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (start) state_nx = S_ACCEPT;
         end
         S_ACCEPT: begin
            if (in_valid) state_nx = S_ENCODE;
         end
         S_ENCODE: begin
            state_nx = S_WRITE;
         end
         S_WRITE: begin
            state_nx = last_q ? S_DONE : S_ACCEPT;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   assign in_ready = (state == S_ACCEPT);
   assign done     = (state == S_DONE);
   // A rejected immediate still passes through WRITE, just without the strobe.
   assign mem_we   = (state == S_WRITE) && !bad_q;

   // ---------------- immediate scatter ----------------
   always_comb begin
      packed_c = tmpl_q;
      unique case (src_q)
         2'b00: begin
            packed_c[31:20] = imm_q[11:0];
         end
         2'b01: begin
            packed_c[31:25] = imm_q[11:5];
            packed_c[11:7]  = imm_q[4:0];
         end
         2'b10: begin
            packed_c[31]    = imm_q[12];
            packed_c[30:25] = imm_q[10:5];
            packed_c[11:8]  = imm_q[4:1];
            packed_c[7]     = imm_q[11];
         end
         default: begin
            packed_c[31]    = imm_q[20];
            packed_c[30:21] = imm_q[10:1];
            packed_c[20]    = imm_q[11];
            packed_c[19:12] = imm_q[19:12];
         end
      endcase
   end

   // ---------------- range check ----------------
`ifdef IMM_RANGE_CHECK_EN
   logic signed [31:0] simm;
   assign simm = imm_q;

   always_comb begin
      bad_c = 1'b0;
      unique case (src_q)
         2'b00, 2'b01: begin
            bad_c = (simm < -32'sd2048) || (simm > 32'sd2047);
         end
         2'b10: begin
            bad_c = (simm < -32'sd4096) || (simm > 32'sd4094) || imm_q[0];
         end
         default: begin
            bad_c = (simm < -32'sd1048576) || (simm > 32'sd1048574)
                    || imm_q[0];
         end
      endcase
   end

   assign err = err_q;
`else
   // Without the check, upper bits and bit 0 are simply dropped.
   logic unused_imm;
   assign unused_imm = ^{imm_q[31:21], imm_q[0], err_q};
   assign bad_c      = 1'b0;
   assign err        = 1'b0;
`endif

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         count     <= '0;
         err_q     <= 1'b0;
         tmpl_q    <= '0;
         imm_q     <= '0;
         src_q     <= '0;
         last_q    <= 1'b0;
         bad_q     <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  mem_addr <= base_addr;
                  count    <= '0;
                  err_q    <= 1'b0;
               end
            end
            S_ACCEPT: begin
               if (in_valid) begin
                  tmpl_q <= instr_tmpl;
                  imm_q  <= imm;
                  src_q  <= immSrc;
                  last_q <= in_last;
               end
            end
            S_ENCODE: begin
               mem_wdata <= packed_c;
               bad_q     <= bad_c;
               if (bad_c) err_q <= 1'b1;
            end
            S_WRITE: begin
               if (!bad_q) begin
                  mem_addr <= mem_addr + ADDR_W'(4);
                  count    <= count + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
